sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
// Positioned, integer-scaled sprite compositor on the VGA pixel stream. Overlays one sprite
// (external ROM + external palette) at a movable (x,y) on a background colour; transparent
// index shows background. Replaces full-screen stretch rendering; divider-free address
// generation; position/enable double-buffered and applied only at frame start (no tearing).
// PARAMETERS
// SPR_W      55  sprite width in texels (1..1023)
// SPR_H      55  sprite height in texels (1..1023)
// ADDR_W     14  ROM address width; SPR_W*SPR_H <= 2**ADDR_W
// IDX_W      4   palette index width (rom_q)
// SCALE_LOG2 0   on-screen texel = 2**SCALE_LOG2 x 2**SCALE_LOG2 pixels (0..3)
// ROM_LAT    1   ROM read latency in vga_clk cycles (1..2)
// TRANSP_IDX 0   palette index treated as transparent
// PORTS
// vga_clk      in   1       pixel clock; all state on posedge
// reset_n      in   1       asynchronous, active-low reset
// DrawX,DrawY  in   10,10   current pixel coordinate from VGA controller
// blank        in   1       1 = active video (colour allowed), 0 = blanking
// pos_x,pos_y  in   10,10   requested sprite top-left (screen pixels)
// en_in        in   1       requested sprite visibility
// pos_wr       in   1       1-cycle strobe: capture pos_x/pos_y/en_in into shadow
// pos_pending  out  1       shadow written, not yet applied
// rom_addr     out  ADDR_W  ROM address (registered)
// rom_q        in   IDX_W   ROM data, valid ROM_LAT cycles after rom_addr
// pal_idx      out  IDX_W   = rom_q, to palette
// pal_r/g/b    in   4 each  palette colour for pal_idx (combinational)
// bg_r/g/b     in   4 each  background colour for pixel DrawX/DrawY
// red,green,blue out 4 each composited colour (registered)
// hit          out  1       sprite opaque at the output pixel
// BEHAVIOUR
// - Reset: shadow/active pos = 0, active en = 0, pos_pending = 0, rom_addr = 0, row_base = 0,
//   all delay-line stages cleared, red/green/blue = 0, hit = 0. Reset mid-frame: sprite hidden
//   until pos_wr + next frame start.
// - frame_start = (DrawX==0 && DrawY==0). On frame_start active <= shadow, pos_pending <= 0.
//   pos_wr on the same cycle bypasses: active <= pos_x/pos_y/en_in, pending stays 0.
//   pos_wr elsewhere: shadow <= inputs, pos_pending <= 1; later writes overwrite.
// - rx = DrawX - ax, ry = DrawY - ay, 11-bit signed. in_box = en && 0<=rx<SPR_W<<S &&
//   0<=ry<SPR_H<<S. Sprite clipped at screen edge; no wrap-around.
// - row_base (ADDR_W): updated on DrawX==0 cycles: ry==0 -> 0; ry>0, in vertical range,
//   ry[S-1:0]==0 -> row_base += SPR_W; else hold. No multiply, no divide.
// - Stage 0 (cycle N, pixel P): rom_addr <= in_box ? row_base + (rx>>S) : rom_addr (hold);
//   in_box, blank, bg captured into delay line.
// - ROM_LAT cycles: rom_q valid; delay line matches so bg/blank/in_box align with rom_q.
// - Output stage, cycle N+1+ROM_LAT: hit <= in_box_d && rom_q!=TRANSP_IDX;
//   rgb <= !blank_d ? 0 : hit ? pal : bg_d. Total latency LAT = ROM_LAT+2 cycles from
//   DrawX/DrawY to red/green/blue; VGA controller hs/vs delayed LAT by integrator.
// - Sprite wider than screen, pos beyond 639/479: fully clipped, hit stays 0, no error.
// TESTING
// - Reset: reset_n=0 mid-line -> rgb=0, hit=0, pos_pending=0 same cycle (async); no sprite after.
// - pos_wr (100,50,en=1) at DrawY=200 -> pos_pending=1; sprite absent rest of frame; at
//   frame_start pending=0; pixel (100,50) rom_addr=0, (154,50) addr=54, (155,50) in_box=0.
// - SCALE_LOG2=1, pos (0,0): pixels (0,0),(1,0),(0,1),(1,1) -> addr 0; (2,2) -> addr 56;
//   (109,109) -> addr 3024.
// - Transparency: rom_q=TRANSP_IDX inside box -> rgb=bg, hit=0; rom_q=3 -> rgb=pal, hit=1,
//   exactly ROM_LAT+2 cycles after pixel presented (check ROM_LAT=1 and 2).
// - blank=0 inside box -> rgb=0 although hit=1; pos (620,470) -> right/bottom clipped, no
//   wrap to column 0 or row 0.
// - pos_wr coincident with frame_start -> new position used this frame, pos_pending stays 0.

Source files
------------

// File: rtl/sprite_blitter_if.sv
// Sprite ROM + palette bus between the blitter (master) and its memories (slave).
// Fixed-latency, no handshake: rom_q is valid ROM_LAT cycles after rom_addr; pal_* follow pal_idx combinationally.
interface sprite_blitter_if #(
  parameter int ADDR_W = 14,
  parameter int IDX_W  = 4
);
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_idx;
  logic [3:0]        pal_r;
  logic [3:0]        pal_g;
  logic [3:0]        pal_b;

  modport master (output rom_addr, output pal_idx,
                  input  rom_q, input pal_r, input pal_g, input pal_b);
  modport slave  (input  rom_addr, input pal_idx,
                  output rom_q, output pal_r, output pal_g, output pal_b);
endinterface

// File: rtl/sprite_blitter.sv
// Positioned, integer-scaled sprite compositor on the VGA pixel stream.
// Position/enable are double-buffered and take effect at frame start; address generation uses no multiply/divide.
module sprite_blitter #(
  parameter int SPR_W      = 55,
  parameter int SPR_H      = 55,
  parameter int ADDR_W     = 14,
  parameter int IDX_W      = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int ROM_LAT    = 1,
  parameter int TRANSP_IDX = 0
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic                en_in,
  input  logic                pos_wr,
  output logic                pos_pending,
  sprite_blitter_if.master    mem,
  input  logic [3:0]          bg_r,
  input  logic [3:0]          bg_g,
  input  logic [3:0]          bg_b,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                hit
);

  localparam logic [13:0] BOX_W    = 14'(SPR_W << SCALE_LOG2);
  localparam logic [13:0] BOX_H    = 14'(SPR_H << SCALE_LOG2);
  localparam logic [9:0]  SUB_MASK = 10'((1 << SCALE_LOG2) - 1);

  logic [9:0]        sx_q, sy_q, sx_d, sy_d;
  logic              sen_q, sen_d;
  logic [9:0]        ax_q, ay_q, ax_d, ay_d;
  logic              aen_q, aen_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROM_LAT:0]  inb_q, blk_q;
  logic [11:0]       bg_q [ROM_LAT+1];
  logic [11:0]       rgb_q, rgb_d;
  logic              hit_q, hit_d;

  logic              frame_start;
  logic [10:0]       rx, ry;
  logic              in_h, in_v, in_box;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  // The active position is used combinationally so a frame-start write also covers pixel (0,0).
  always_comb begin
    sx_d   = sx_q;
    sy_d   = sy_q;
    sen_d  = sen_q;
    ax_d   = ax_q;
    ay_d   = ay_q;
    aen_d  = aen_q;
    pend_d = pend_q;
    if (pos_wr) begin
      sx_d  = pos_x;
      sy_d  = pos_y;
      sen_d = en_in;
    end
    if (frame_start) begin
      pend_d = 1'b0;
      if (pos_wr) begin
        ax_d  = pos_x;
        ay_d  = pos_y;
        aen_d = en_in;
      end else begin
        ax_d  = sx_q;
        ay_d  = sy_q;
        aen_d = sen_q;
      end
    end else if (pos_wr) begin
      pend_d = 1'b1;
    end
  end

  // Both operands are 10-bit, so bit 10 of the difference is the sign.
  assign rx     = {1'b0, DrawX} - {1'b0, ax_d};
  assign ry     = {1'b0, DrawY} - {1'b0, ay_d};
  assign in_h   = !rx[10] && ({4'b0, rx[9:0]} < BOX_W);
  assign in_v   = !ry[10] && ({4'b0, ry[9:0]} < BOX_H);
  assign in_box = aen_d && in_h && in_v;

  always_comb begin
    row_base_d = row_base_q;
    if (DrawX == 10'd0) begin
      if (ry == 11'd0) begin
        row_base_d = '0;
      end else if (in_v && ((ry[9:0] & SUB_MASK) == 10'd0)) begin
        row_base_d = row_base_q + ADDR_W'(SPR_W);
      end
    end
    addr_d = in_box ? row_base_d + ADDR_W'(rx[9:0] >> SCALE_LOG2) : addr_q;
  end

  always_comb begin
    hit_d = inb_q[ROM_LAT] && (mem.rom_q != IDX_W'(TRANSP_IDX));
    rgb_d = bg_q[ROM_LAT];
    if (!blk_q[ROM_LAT]) begin
      rgb_d = 12'd0;
    end else if (hit_d) begin
      rgb_d = {mem.pal_r, mem.pal_g, mem.pal_b};
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q       <= '0;
      sy_q       <= '0;
      sen_q      <= 1'b0;
      ax_q       <= '0;
      ay_q       <= '0;
      aen_q      <= 1'b0;
      pend_q     <= 1'b0;
      row_base_q <= '0;
      addr_q     <= '0;
      inb_q      <= '0;
      blk_q      <= '0;
      for (int i = 0; i <= ROM_LAT; i++) bg_q[i] <= '0;
      rgb_q      <= '0;
      hit_q      <= 1'b0;
    end else begin
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      sen_q      <= sen_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      aen_q      <= aen_d;
      pend_q     <= pend_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      inb_q[0]   <= in_box;
      blk_q[0]   <= blank;
      bg_q[0]    <= {bg_r, bg_g, bg_b};
      for (int i = 1; i <= ROM_LAT; i++) begin
        inb_q[i] <= inb_q[i-1];
        blk_q[i] <= blk_q[i-1];
        bg_q[i]  <= bg_q[i-1];
      end
      rgb_q      <= rgb_d;
      hit_q      <= hit_d;
    end
  end

  assign mem.rom_addr = addr_q;
  assign mem.pal_idx  = mem.rom_q;
  assign pos_pending  = pend_q;
  assign {red, green, blue} = rgb_q;
  assign hit          = hit_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: three instances (scale 0/lat 1, scale 1/lat 1, scale 0/lat 2) share one pixel stream.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, en_in, pos_wr;
  logic [3:0] bg_r, bg_g, bg_b;

  logic       a_pend, b_pend, c_pend, a_hit, b_hit, c_hit;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] BG   = 12'hABC;
  localparam logic [11:0] PAL3 = 12'h3C6;

  logic [3:0] rom_mem [16384];
  logic [3:0] r0, r1, r2a, r2b;

  sprite_blitter_if #(.ADDR_W(14), .IDX_W(4)) m0 ();
  sprite_blitter_if #(.ADDR_W(14), .IDX_W(4)) m1 ();
  sprite_blitter_if #(.ADDR_W(14), .IDX_W(4)) m2 ();

  always #5 clk = ~clk;

  // Behavioural ROMs (latency 1, 1, 2) sharing one image, and a fixed palette.
  always_ff @(posedge clk) begin
    r0  <= rom_mem[m0.rom_addr];
    r1  <= rom_mem[m1.rom_addr];
    r2a <= rom_mem[m2.rom_addr];
    r2b <= r2a;
  end
  assign m0.rom_q = r0;
  assign m1.rom_q = r1;
  assign m2.rom_q = r2b;
  assign m0.pal_r = m0.pal_idx;  assign m0.pal_g = ~m0.pal_idx;  assign m0.pal_b = m0.pal_idx ^ 4'h5;
  assign m1.pal_r = m1.pal_idx;  assign m1.pal_g = ~m1.pal_idx;  assign m1.pal_b = m1.pal_idx ^ 4'h5;
  assign m2.pal_r = m2.pal_idx;  assign m2.pal_g = ~m2.pal_idx;  assign m2.pal_b = m2.pal_idx ^ 4'h5;

  sprite_blitter #(.SCALE_LOG2(0), .ROM_LAT(1)) dut_a (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .en_in(en_in), .pos_wr(pos_wr), .pos_pending(a_pend),
    .mem(m0.master), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .red(a_r), .green(a_g), .blue(a_b), .hit(a_hit));

  sprite_blitter #(.SCALE_LOG2(1), .ROM_LAT(1)) dut_b (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .en_in(en_in), .pos_wr(pos_wr), .pos_pending(b_pend),
    .mem(m1.master), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .red(b_r), .green(b_g), .blue(b_b), .hit(b_hit));

  sprite_blitter #(.SCALE_LOG2(0), .ROM_LAT(2)) dut_c (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .en_in(en_in), .pos_wr(pos_wr), .pos_pending(c_pend),
    .mem(m2.master), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .red(c_r), .green(c_g), .blue(c_b), .hit(c_hit));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic wr);
    @(negedge clk);
    DrawX  = x;
    DrawY  = y;
    pos_wr = wr;
    @(posedge clk);
    #1;
    pos_wr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) rom_mem[i] = 4'd3;
    rom_mem[1] = 4'd0;
    reset_n = 1'b0;
    DrawX = 10'd0;  DrawY = 10'd0;  blank = 1'b0;
    pos_x = 10'd0;  pos_y = 10'd0;  en_in = 1'b0;  pos_wr = 1'b0;
    {bg_r, bg_g, bg_b} = BG;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", {a_r, a_g, a_b}, 12'h000);
    chk("reset_hit", a_hit, 1'b0);
    chk("reset_pending", a_pend, 1'b0);
    chk("reset_addr", m0.rom_addr, 14'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Mid-frame write: pending, sprite stays hidden for the rest of this frame
    pos_x = 10'd100;  pos_y = 10'd50;  en_in = 1'b1;
    pix(10'd5, 10'd200, 1'b1);
    chk("wr_pending", a_pend, 1'b1);
    blank = 1'b1;
    pix(10'd120, 10'd210, 1'b0);
    pix(10'd121, 10'd210, 1'b0);
    pix(10'd122, 10'd210, 1'b0);
    chk("hidden_hit", a_hit, 1'b0);
    chk("hidden_rgb", {a_r, a_g, a_b}, BG);

    // Frame start applies (100,50)
    blank = 1'b0;
    pix(10'd0, 10'd0, 1'b0);
    chk("fs_pending", a_pend, 1'b0);
    pix(10'd0, 10'd50, 1'b0);
    pix(10'd100, 10'd50, 1'b0);
    chk("addr_100_50", m0.rom_addr, 14'd0);
    pix(10'd101, 10'd50, 1'b0);
    blank = 1'b1;
    pix(10'd154, 10'd50, 1'b0);
    chk("addr_154_50", m0.rom_addr, 14'd54);
    chk("blank_hit", a_hit, 1'b1);
    chk("blank_rgb", {a_r, a_g, a_b}, 12'h000);
    blank = 1'b0;
    pix(10'd155, 10'd50, 1'b0);
    chk("addr_155_hold", m0.rom_addr, 14'd54);
    chk("lat1_early_rgb", {a_r, a_g, a_b}, 12'h000);
    chk("lat2_blank_hit", c_hit, 1'b1);
    pix(10'd156, 10'd50, 1'b0);
    chk("lat1_rgb", {a_r, a_g, a_b}, PAL3);
    chk("lat1_hit", a_hit, 1'b1);
    chk("lat2_early_rgb", {c_r, c_g, c_b}, 12'h000);
    pix(10'd157, 10'd50, 1'b0);
    chk("lat2_rgb", {c_r, c_g, c_b}, PAL3);
    chk("lat2_hit", c_hit, 1'b1);
    chk("outside_hit", a_hit, 1'b0);

    // Transparent texel (address 1) shows background
    blank = 1'b1;
    pix(10'd101, 10'd50, 1'b0);
    pix(10'd300, 10'd50, 1'b0);
    pix(10'd300, 10'd50, 1'b0);
    chk("transp_rgb", {a_r, a_g, a_b}, BG);
    chk("transp_hit", a_hit, 1'b0);
    pix(10'd300, 10'd50, 1'b0);
    chk("transp_rgb_lat2", {c_r, c_g, c_b}, BG);
    chk("transp_hit_lat2", c_hit, 1'b0);

    // Clipping at (620,470): no wrap to column 0 or row 0
    pos_x = 10'd620;  pos_y = 10'd470;
    pix(10'd10, 10'd300, 1'b1);
    pix(10'd0, 10'd0, 1'b0);
    pix(10'd0, 10'd470, 1'b0);
    pix(10'd639, 10'd470, 1'b0);
    chk("clip_addr_639", m0.rom_addr, 14'd19);
    pix(10'd0, 10'd470, 1'b0);
    chk("clip_col0_hold", m0.rom_addr, 14'd19);
    for (int y = 471; y <= 479; y++) pix(10'd0, 10'(y), 1'b0);
    pix(10'd620, 10'd479, 1'b0);
    chk("clip_addr_479", m0.rom_addr, 14'd495);
    chk("clip_addr_479_s1", m1.rom_addr, 14'd220);
    pix(10'd0, 10'd0, 1'b0);
    pix(10'd5, 10'd0, 1'b0);
    chk("clip_row0_hold", m0.rom_addr, 14'd495);
    pix(10'd6, 10'd0, 1'b0);
    pix(10'd7, 10'd0, 1'b0);
    chk("clip_row0_hit", a_hit, 1'b0);
    chk("clip_row0_rgb", {a_r, a_g, a_b}, BG);

    // Write at frame start bypasses the pending shadow (300,300)
    pos_x = 10'd300;  pos_y = 10'd300;
    pix(10'd10, 10'd100, 1'b1);
    chk("shadow_pending", a_pend, 1'b1);
    pos_x = 10'd0;  pos_y = 10'd0;
    pix(10'd0, 10'd0, 1'b1);
    chk("bypass_pending", a_pend, 1'b0);
    chk("s1_addr_0_0", m1.rom_addr, 14'd0);
    pix(10'd1, 10'd0, 1'b0);
    chk("s1_addr_1_0", m1.rom_addr, 14'd0);
    pix(10'd0, 10'd1, 1'b0);
    chk("s1_addr_0_1", m1.rom_addr, 14'd0);
    pix(10'd1, 10'd1, 1'b0);
    chk("s1_addr_1_1", m1.rom_addr, 14'd0);
    pix(10'd0, 10'd2, 1'b0);
    chk("s1_addr_0_2", m1.rom_addr, 14'd55);
    pix(10'd2, 10'd2, 1'b0);
    chk("s1_addr_2_2", m1.rom_addr, 14'd56);
    chk("s0_addr_2_2", m0.rom_addr, 14'd112);
    for (int y = 3; y <= 109; y++) pix(10'd0, 10'(y), 1'b0);
    pix(10'd109, 10'd109, 1'b0);
    chk("s1_addr_109", m1.rom_addr, 14'd3024);
    pos_x = 10'd300;  pos_y = 10'd300;
    pix(10'd110, 10'd109, 1'b1);
    pix(10'd111, 10'd109, 1'b0);
    chk("s1_hit_109", b_hit, 1'b1);
    chk("s1_rgb_109", {b_r, b_g, b_b}, PAL3);

    // Asynchronous reset mid-line
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_rgb", {b_r, b_g, b_b}, 12'h000);
    chk("areset_hit", b_hit, 1'b0);
    chk("areset_pending", a_pend, 1'b0);
    chk("areset_addr", m1.rom_addr, 14'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pix(10'd5, 10'd5, 1'b0);
    pix(10'd6, 10'd5, 1'b0);
    pix(10'd7, 10'd5, 1'b0);
    chk("post_reset_hit", a_hit, 1'b0);
    chk("post_reset_rgb", {a_r, a_g, a_b}, BG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
